// File: rtl/uart_icb_arb_pkg.sv
// uart_icb_arb_pkg: shared arbiter states, master ids and UART register addresses
package uart_icb_arb_pkg;
  localparam int PA_SIZE = 32;
  localparam logic [31:0] UART_CTRL_ADDR = 32'h0000_0008;
  localparam logic [31:0] DATA_REG_ADDR = 32'h0000_0000;
  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;
  typedef enum logic [1:0] {ARB_IDLE = 2'd0, ARB_CMD = 2'd1, ARB_RSP = 2'd2} arb_state_e;
endpackage

// File: rtl/uart_icb_arb_if.sv
// uart_icb_arb_if: ICB command/response bundle matching the uart_ctrl slave port
interface uart_icb_arb_if #(parameter int AW = 32, parameter int DW = 32);
  logic cmd_valid;
  logic cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic cmd_read;
  logic [DW-1:0] cmd_wdata;
  logic rsp_valid;
  logic rsp_ready;
  logic [DW-1:0] rsp_rdata;
  modport master(output cmd_valid, cmd_addr, cmd_read, cmd_wdata, rsp_ready,
                 input cmd_ready, rsp_valid, rsp_rdata);
  modport slave(input cmd_valid, cmd_addr, cmd_read, cmd_wdata, rsp_ready,
                output cmd_ready, rsp_valid, rsp_rdata);
endinterface

// File: rtl/uart_rr_pick2.sv
// uart_rr_pick2: two-way requester pick, prio breaks ties
module uart_rr_pick2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic       sel,
  output logic       any
);
  assign any = |req;
  assign sel = &req ? prio : req[1];
endmodule

// File: rtl/uart_icb_arb.sv
// uart_icb_arb: round-robin two-master ICB arbiter with one outstanding transaction
module uart_icb_arb
  import uart_icb_arb_pkg::*;
#(
  parameter int AW = PA_SIZE,
  parameter int DW = PA_SIZE
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_icb_arb_if.slave  m0,
  uart_icb_arb_if.slave  m1,
  uart_icb_arb_if.master s,
  output logic           owner
);
  arb_state_e state;
  logic prio, sel, any, cur, fwd, rsp;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  uart_rr_pick2 u_pick (.req({m1.cmd_valid, m0.cmd_valid}), .prio(prio), .sel(sel), .any(any));
  // grant follows the live pick only in idle; once committed it is frozen on owner
  always_comb begin
    cur = (state == ARB_IDLE) ? sel : owner;
    rsp = (state == ARB_RSP);
    fwd = !rsp && (cur ? m1.cmd_valid : m0.cmd_valid);
    addr = cur ? m1.cmd_addr : m0.cmd_addr;
    wdata = cur ? m1.cmd_wdata : m0.cmd_wdata;
  end
  assign s.cmd_valid = fwd;
  assign s.cmd_addr = fwd ? addr : '0;
  assign s.cmd_wdata = fwd ? wdata : '0;
  assign s.cmd_read = fwd && (cur ? m1.cmd_read : m0.cmd_read);
  assign m0.cmd_ready = fwd && cur == ARB_M0 && s.cmd_ready;
  assign m1.cmd_ready = fwd && cur == ARB_M1 && s.cmd_ready;
  assign m0.rsp_valid = rsp && owner == ARB_M0 && s.rsp_valid;
  assign m1.rsp_valid = rsp && owner == ARB_M1 && s.rsp_valid;
  assign m0.rsp_rdata = (rsp && owner == ARB_M0) ? s.rsp_rdata : '0;
  assign m1.rsp_rdata = (rsp && owner == ARB_M1) ? s.rsp_rdata : '0;
  assign s.rsp_ready = rsp && (owner ? m1.rsp_ready : m0.rsp_ready);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
      owner <= ARB_M0;
      prio <= ARB_M0;
    end else begin
      case (state)
        ARB_IDLE: if (any) begin
          owner <= sel;
          state <= s.cmd_ready ? ARB_RSP : ARB_CMD;
        end
        ARB_CMD: state <= !fwd ? ARB_IDLE : s.cmd_ready ? ARB_RSP : ARB_CMD;
        ARB_RSP: if (s.rsp_valid && s.rsp_ready) begin
          state <= ARB_IDLE;
          prio <= ~owner;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_icb_arb.sv
// tb_uart_icb_arb: directed self-checking bench for the two-master ICB arbiter
module tb_uart_icb_arb;
  import uart_icb_arb_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic owner;
  int checks = 0;
  int errors = 0;
  uart_icb_arb_if #(.AW(32), .DW(32)) m0_if ();
  uart_icb_arb_if #(.AW(32), .DW(32)) m1_if ();
  uart_icb_arb_if #(.AW(32), .DW(32)) s_if ();
  uart_icb_arb #(.AW(32), .DW(32)) dut (.clk(clk), .rst_n(rst_n), .m0(m0_if.slave), .m1(m1_if.slave), .s(s_if.master), .owner(owner));
  always #5 clk = ~clk;

  task automatic clr();
    m0_if.cmd_valid = 0; m0_if.cmd_addr = '0; m0_if.cmd_read = 0; m0_if.cmd_wdata = '0; m0_if.rsp_ready = 0;
    m1_if.cmd_valid = 0; m1_if.cmd_addr = '0; m1_if.cmd_read = 0; m1_if.cmd_wdata = '0; m1_if.rsp_ready = 0;
    s_if.cmd_ready = 0; s_if.rsp_valid = 0; s_if.rsp_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 0; clr();
    @(negedge clk); @(negedge clk); rst_n = 1;
  endtask

  task automatic test_reset();
    @(negedge clk); rst_n = 0; clr();
    s_if.rsp_valid = 1; s_if.cmd_ready = 1; s_if.rsp_rdata = 32'hDEAD_BEEF; m0_if.rsp_ready = 1; m1_if.rsp_ready = 1;
    #1;
    checks++; if (owner !== 1'b0) begin errors++; $display("FAIL rst_owner: got %b exp 0", owner); end
    checks++; if (s_if.cmd_valid !== 1'b0) begin errors++; $display("FAIL rst_s_valid: got %b exp 0", s_if.cmd_valid); end
    checks++; if (s_if.rsp_ready !== 1'b0) begin errors++; $display("FAIL rst_s_rsp_ready: got %b exp 0", s_if.rsp_ready); end
    checks++; if ({s_if.cmd_addr, s_if.cmd_wdata, s_if.cmd_read} !== 65'd0) begin errors++; $display("FAIL rst_s_cmd: got %h exp 0", {s_if.cmd_addr, s_if.cmd_wdata, s_if.cmd_read}); end
    checks++; if ({m0_if.cmd_ready, m1_if.cmd_ready, m0_if.rsp_valid, m1_if.rsp_valid} !== 4'b0) begin errors++; $display("FAIL rst_m_flags: got %b exp 0000", {m0_if.cmd_ready, m1_if.cmd_ready, m0_if.rsp_valid, m1_if.rsp_valid}); end
    checks++; if ({m0_if.rsp_rdata, m1_if.rsp_rdata} !== 64'd0) begin errors++; $display("FAIL rst_rdata: got %h exp 0", {m0_if.rsp_rdata, m1_if.rsp_rdata}); end
    @(negedge clk); clr(); rst_n = 1;
  endtask

  task automatic test_m0_write();
    do_reset();
    @(negedge clk);
    m0_if.cmd_valid = 1; m0_if.cmd_addr = UART_CTRL_ADDR; m0_if.cmd_read = 0; m0_if.cmd_wdata = 32'h0000_0005; s_if.cmd_ready = 1;
    #1;
    checks++; if (s_if.cmd_valid !== 1'b1) begin errors++; $display("FAIL w_s_valid: got %b exp 1", s_if.cmd_valid); end
    checks++; if (s_if.cmd_addr !== UART_CTRL_ADDR) begin errors++; $display("FAIL w_s_addr: got %h exp %h", s_if.cmd_addr, UART_CTRL_ADDR); end
    checks++; if (s_if.cmd_wdata !== 32'h5 || s_if.cmd_read !== 1'b0) begin errors++; $display("FAIL w_s_data: got %h/%b exp 5/0", s_if.cmd_wdata, s_if.cmd_read); end
    checks++; if ({m0_if.cmd_ready, m1_if.cmd_ready} !== 2'b10) begin errors++; $display("FAIL w_ready: got %b exp 10", {m0_if.cmd_ready, m1_if.cmd_ready}); end
    @(negedge clk);
    m0_if.cmd_valid = 0; s_if.cmd_ready = 0; s_if.rsp_valid = 1; m0_if.rsp_ready = 1;
    #1;
    checks++; if ({m0_if.rsp_valid, m1_if.rsp_valid} !== 2'b10) begin errors++; $display("FAIL w_rsp_valid: got %b exp 10", {m0_if.rsp_valid, m1_if.rsp_valid}); end
    checks++; if (s_if.rsp_ready !== 1'b1 || s_if.cmd_valid !== 1'b0) begin errors++; $display("FAIL w_rsp_ready: got %b/%b exp 1/0", s_if.rsp_ready, s_if.cmd_valid); end
    @(negedge clk); #1;
    checks++; if ({m0_if.rsp_valid, s_if.rsp_ready} !== 2'b00) begin errors++; $display("FAIL w_back_idle: got %b exp 00", {m0_if.rsp_valid, s_if.rsp_ready}); end
    clr();
  endtask

  task automatic test_back_to_back();
    logic g;
    logic [31:0] exp_d;
    do_reset();
    @(negedge clk);
    m0_if.cmd_valid = 1; m0_if.cmd_read = 1; m0_if.cmd_addr = DATA_REG_ADDR; m0_if.rsp_ready = 1;
    m1_if.cmd_valid = 1; m1_if.cmd_read = 1; m1_if.cmd_addr = DATA_REG_ADDR; m1_if.rsp_ready = 1;
    s_if.cmd_ready = 1; s_if.rsp_valid = 1;
    for (int k = 0; k < 4; k++) begin
      g = k[0];
      exp_d = g ? 32'h3C : 32'hA5;
      if (k != 0) @(negedge clk);
      s_if.rsp_rdata = '0;
      #1;
      checks++; if ({m1_if.cmd_ready, m0_if.cmd_ready} !== (g ? 2'b10 : 2'b01)) begin errors++; $display("FAIL b2b_grant%0d: got %b exp %b", k, {m1_if.cmd_ready, m0_if.cmd_ready}, g ? 2'b10 : 2'b01); end
      checks++; if (s_if.rsp_ready !== 1'b0) begin errors++; $display("FAIL b2b_idle_rsp%0d: got %b exp 0", k, s_if.rsp_ready); end
      @(negedge clk);
      s_if.rsp_rdata = exp_d;
      #1;
      checks++; if (owner !== g) begin errors++; $display("FAIL b2b_owner%0d: got %b exp %b", k, owner, g); end
      checks++; if ((g ? m1_if.rsp_rdata : m0_if.rsp_rdata) !== exp_d) begin errors++; $display("FAIL b2b_rdata%0d: got %h exp %h", k, g ? m1_if.rsp_rdata : m0_if.rsp_rdata, exp_d); end
      checks++; if ((g ? m0_if.rsp_rdata : m1_if.rsp_rdata) !== 32'h0) begin errors++; $display("FAIL b2b_other%0d: got %h exp 0", k, g ? m0_if.rsp_rdata : m1_if.rsp_rdata); end
      checks++; if ({m1_if.rsp_valid, m0_if.rsp_valid, m1_if.cmd_ready, m0_if.cmd_ready} !== (g ? 4'b1000 : 4'b0100)) begin errors++; $display("FAIL b2b_rsp%0d: got %b exp %b", k, {m1_if.rsp_valid, m0_if.rsp_valid, m1_if.cmd_ready, m0_if.cmd_ready}, g ? 4'b1000 : 4'b0100); end
    end
    @(negedge clk); clr();
  endtask

  task automatic test_cmd_stall();
    do_reset();
    @(negedge clk);
    m0_if.cmd_valid = 1; m0_if.cmd_addr = UART_CTRL_ADDR; m0_if.cmd_wdata = 32'h7; m0_if.rsp_ready = 1;
    for (int k = 0; k < 3; k++) begin
      if (k != 0) @(negedge clk);
      if (k == 1) begin m1_if.cmd_valid = 1; m1_if.cmd_addr = DATA_REG_ADDR; m1_if.cmd_read = 1; m1_if.rsp_ready = 1; end
      #1;
      checks++; if (s_if.cmd_addr !== UART_CTRL_ADDR || s_if.cmd_valid !== 1'b1) begin errors++; $display("FAIL stall_addr%0d: got %h/%b exp %h/1", k, s_if.cmd_addr, s_if.cmd_valid, UART_CTRL_ADDR); end
      checks++; if ({m0_if.cmd_ready, m1_if.cmd_ready} !== 2'b00) begin errors++; $display("FAIL stall_ready%0d: got %b exp 00", k, {m0_if.cmd_ready, m1_if.cmd_ready}); end
      if (k != 0) begin
        checks++; if (owner !== 1'b0) begin errors++; $display("FAIL stall_owner%0d: got %b exp 0", k, owner); end
      end
    end
    @(negedge clk);
    s_if.cmd_ready = 1;
    #1;
    checks++; if ({m0_if.cmd_ready, m1_if.cmd_ready} !== 2'b10 || s_if.cmd_addr !== UART_CTRL_ADDR) begin errors++; $display("FAIL stall_accept: got %b/%h exp 10/%h", {m0_if.cmd_ready, m1_if.cmd_ready}, s_if.cmd_addr, UART_CTRL_ADDR); end
    @(negedge clk);
    m0_if.cmd_valid = 0; s_if.rsp_valid = 1;
    #1;
    checks++; if ({m0_if.rsp_valid, m1_if.cmd_ready, s_if.cmd_valid} !== 3'b100) begin errors++; $display("FAIL stall_rsp: got %b exp 100", {m0_if.rsp_valid, m1_if.cmd_ready, s_if.cmd_valid}); end
    @(negedge clk);
    s_if.rsp_valid = 0;
    #1;
    checks++; if (m1_if.cmd_ready !== 1'b1 || s_if.cmd_addr !== DATA_REG_ADDR) begin errors++; $display("FAIL stall_m1_served: got %b/%h exp 1/%h", m1_if.cmd_ready, s_if.cmd_addr, DATA_REG_ADDR); end
    @(negedge clk);
    m1_if.cmd_valid = 0;
    #1;
    checks++; if (owner !== 1'b1) begin errors++; $display("FAIL stall_owner_m1: got %b exp 1", owner); end
    clr();
  endtask

  task automatic test_rsp_hold();
    do_reset();
    @(negedge clk);
    m1_if.cmd_valid = 1; m1_if.cmd_read = 1; m1_if.cmd_addr = DATA_REG_ADDR; s_if.cmd_ready = 1;
    @(negedge clk);
    m1_if.cmd_valid = 0; m1_if.rsp_ready = 0; s_if.rsp_valid = 1; s_if.rsp_rdata = 32'h3C;
    m0_if.cmd_valid = 1; m0_if.cmd_addr = UART_CTRL_ADDR; m0_if.rsp_ready = 1;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) @(negedge clk);
      #1;
      checks++; if (m1_if.rsp_valid !== 1'b1 || m1_if.rsp_rdata !== 32'h3C) begin errors++; $display("FAIL hold_rsp%0d: got %b/%h exp 1/3c", k, m1_if.rsp_valid, m1_if.rsp_rdata); end
      checks++; if ({s_if.cmd_valid, m0_if.cmd_ready, s_if.rsp_ready} !== 3'b000) begin errors++; $display("FAIL hold_block%0d: got %b exp 000", k, {s_if.cmd_valid, m0_if.cmd_ready, s_if.rsp_ready}); end
    end
    @(negedge clk);
    m1_if.rsp_ready = 1;
    #1;
    checks++; if (s_if.rsp_ready !== 1'b1) begin errors++; $display("FAIL hold_release: got %b exp 1", s_if.rsp_ready); end
    @(negedge clk);
    s_if.rsp_valid = 0;
    #1;
    checks++; if (m0_if.cmd_ready !== 1'b1 || s_if.cmd_addr !== UART_CTRL_ADDR) begin errors++; $display("FAIL hold_m0_next: got %b/%h exp 1/%h", m0_if.cmd_ready, s_if.cmd_addr, UART_CTRL_ADDR); end
    @(negedge clk); clr();
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    m0_if.cmd_valid = 1; m0_if.rsp_ready = 1; s_if.cmd_ready = 1;
    @(negedge clk);
    m0_if.cmd_valid = 0; s_if.rsp_valid = 1;
    @(negedge clk);
    s_if.rsp_valid = 0; m1_if.cmd_valid = 1;
    @(negedge clk);
    m1_if.cmd_valid = 0; s_if.rsp_valid = 1; s_if.rsp_rdata = 32'h3C;
    #1;
    checks++; if (owner !== 1'b1 || m1_if.rsp_valid !== 1'b1) begin errors++; $display("FAIL mid_pre: got %b/%b exp 1/1", owner, m1_if.rsp_valid); end
    m1_if.rsp_ready = 1; rst_n = 0;
    #1;
    checks++; if ({owner, m1_if.rsp_valid, s_if.rsp_ready} !== 3'b000 || m1_if.rsp_rdata !== 32'h0) begin errors++; $display("FAIL mid_rst: got %b/%h exp 000/0", {owner, m1_if.rsp_valid, s_if.rsp_ready}, m1_if.rsp_rdata); end
    @(negedge clk);
    rst_n = 1;
    #1;
    checks++; if ({m0_if.rsp_valid, m1_if.rsp_valid, s_if.rsp_ready} !== 3'b000) begin errors++; $display("FAIL mid_late_rsp: got %b exp 000", {m0_if.rsp_valid, m1_if.rsp_valid, s_if.rsp_ready}); end
    @(negedge clk);
    s_if.rsp_valid = 0; m0_if.cmd_valid = 1; m1_if.cmd_valid = 1;
    #1;
    checks++; if ({m0_if.cmd_ready, m1_if.cmd_ready} !== 2'b10) begin errors++; $display("FAIL mid_prio: got %b exp 10", {m0_if.cmd_ready, m1_if.cmd_ready}); end
    @(negedge clk); clr();
  endtask

  initial begin
    clr();
    test_reset();
    test_m0_write();
    test_back_to_back();
    test_cmd_stall();
    test_rsp_hold();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
